// File: rtl/stream_demux_pkg.sv
// Shared sizing constants and the push-decoder helper for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;

    localparam int NUM_OUT    = 4;
    localparam int SEL_W      = 2;
    localparam int SLOT_DEPTH = 2;
    localparam int PTR_W      = 1;
    localparam int CNT_W      = 2;

    function automatic logic [NUM_OUT-1:0] onehot_sel(input logic [SEL_W-1:0] sel);
        logic [NUM_OUT-1:0] one;
        one = NUM_OUT'(1);
        return one << sel;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// Two-entry ring FIFO holding the beats queued for one demultiplexer output.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [BITS-1:0] din,
    input  logic            pop,
    output logic [BITS-1:0] dout,
    output logic            valid,
    output logic            full
);

    logic [BITS-1:0]  storage_q [SLOT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    // Guard locally too, so a slot can never overrun or underrun on its own.
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;

    assign valid = (count_q != '0);
    assign full  = (count_q == CNT_W'(SLOT_DEPTH));
    assign dout  = storage_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: storage is reset as well because out1..out4 must read zero after reset.
            for (int i = 0; i < SLOT_DEPTH; i++) storage_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                storage_q[wr_ptr_q] <= din;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stream_demux4.sv
// 1-to-4 valid/ready stream demultiplexer: each beat is steered by select into a per-output 2-entry slot.
module stream_demux4
    import stream_demux_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   select,
    input  logic [BITS-1:0]    in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [BITS-1:0]    out1,
    output logic [BITS-1:0]    out2,
    output logic [BITS-1:0]    out3,
    output logic [BITS-1:0]    out4,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready
);

    logic [NUM_OUT-1:0] full;
    logic [NUM_OUT-1:0] push;
    logic [BITS-1:0]    dout [NUM_OUT];

    // Ready depends only on the targeted slot's registered fill level, never on a same-cycle pop.
    assign in_ready = ~full[select];
    assign push     = (in_valid && in_ready) ? onehot_sel(select) : '0;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
        demux_slot #(.BITS(BITS)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .din   (in_data),
            .pop   (out_ready[g]),
            .dout  (dout[g]),
            .valid (out_valid[g]),
            .full  (full[g])
        );
    end

    assign out1 = dout[0];
    assign out2 = dout[1];
    assign out3 = dout[2];
    assign out4 = dout[3];

endmodule

// File: tb/tb_stream_demux4.sv
// Directed and randomised self-checking bench for stream_demux4.
module tb_stream_demux4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  select;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out1, out2, out3, out4;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb [4][$];
    logic [15:0] outs [4];

    stream_demux4 #(.BITS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .select    (select),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    assign outs[0] = out1;
    assign outs[1] = out2;
    assign outs[2] = out3;
    assign outs[3] = out4;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs sampled off-edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d);
        in_valid = v;
        select   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        logic [15:0] beats [4];
        logic        stalled;
        logic [3:0]  exp_valid;

        beats[0] = 16'h1111; beats[1] = 16'h2222; beats[2] = 16'h3333; beats[3] = 16'h4444;

        // 1: reset with a pending beat
        rst = 1'b1; out_ready = 4'b0000;
        drive(1'b1, 2'd2, 16'hDEAD);
        tick(); tick();
        rst = 1'b0;
        drive(1'b0, 2'd2, 16'hDEAD);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
        check("rst_out1", 32'(out1), 32'h0);
        check("rst_out2", 32'(out2), 32'h0);
        check("rst_out3", 32'(out3), 32'h0);
        check("rst_out4", 32'(out4), 32'h0);
        tick();
        check("rst_nobeat", 32'(out_valid), 32'h0);

        // 2: steering, one beat per output
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), beats[i]);
            check("steer_ready", 32'(in_ready), 32'h1);
            tick();
            check("steer_valid", 32'(out_valid), 32'(4'b0001 << i));
            check("steer_data", 32'(outs[i]), 32'(beats[i]));
        end
        drive(1'b0, 2'd0, 16'h0);
        tick();
        check("steer_drain", 32'(out_valid), 32'h0);

        // 3: backpressure on slot 2, no blocking of slot 0
        out_ready = 4'b1011;
        drive(1'b1, 2'd2, 16'h00A0);
        check("bp_rdy_a0", 32'(in_ready), 32'h1);
        tick();
        drive(1'b1, 2'd2, 16'h00A1);
        check("bp_rdy_a1", 32'(in_ready), 32'h1);
        tick();
        drive(1'b0, 2'd2, 16'h00A2);
        check("bp_full", 32'(in_ready), 32'h0);
        drive(1'b1, 2'd0, 16'h00B0);
        check("bp_cross_rdy", 32'(in_ready), 32'h1);
        tick();
        check("bp_cross_valid", 32'(out_valid), 32'b0101);
        check("bp_cross_data", 32'(out1), 32'h00B0);
        drive(1'b1, 2'd2, 16'h00A2);
        check("bp_a2_blocked", 32'(in_ready), 32'h0);
        tick();
        check("bp_hold_valid", 32'(out_valid), 32'b0100);
        check("bp_head_a0", 32'(out3), 32'h00A0);
        out_ready = 4'b1111;
        #1;
        check("bp_no_passthru", 32'(in_ready), 32'h0);
        tick();
        check("bp_head_a1", 32'(out3), 32'h00A1);
        check("bp_rdy_after_pop", 32'(in_ready), 32'h1);
        tick();
        check("bp_head_a2", 32'(out3), 32'h00A2);
        check("bp_a2_valid", 32'(out_valid), 32'b0100);
        drive(1'b0, 2'd2, 16'h0);
        tick();
        check("bp_drain", 32'(out_valid), 32'h0);

        // 4: simultaneous push and pop at count 1
        out_ready = 4'b0000;
        drive(1'b1, 2'd1, 16'h0055);
        tick();
        check("pp_head55", 32'(out2), 32'h0055);
        out_ready = 4'b0010;
        drive(1'b1, 2'd1, 16'h0066);
        check("pp_ready", 32'(in_ready), 32'h1);
        tick();
        check("pp_head66", 32'(out2), 32'h0066);
        check("pp_valid", 32'(out_valid), 32'b0010);
        drive(1'b0, 2'd1, 16'h0);
        tick();
        check("pp_count1", 32'(out_valid), 32'h0);

        // 5: reset mid-stream discards buffered beats
        out_ready = 4'b0000;
        drive(1'b1, 2'd0, 16'h00C0); tick();
        drive(1'b1, 2'd0, 16'h00C1); tick();
        drive(1'b1, 2'd3, 16'h00D0); tick();
        drive(1'b1, 2'd3, 16'h00D1); tick();
        drive(1'b0, 2'd0, 16'h0);
        check("mr_full0", 32'(in_ready), 32'h0);
        drive(1'b0, 2'd3, 16'h0);
        check("mr_full3", 32'(in_ready), 32'h0);
        check("mr_pre_valid", 32'(out_valid), 32'b1001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid", 32'(out_valid), 32'h0);
        check("mr_out4", 32'(out4), 32'h0);
        drive(1'b1, 2'd3, 16'h0077);
        tick();
        drive(1'b0, 2'd3, 16'h0);
        check("mr_only_valid", 32'(out_valid), 32'b1000);
        check("mr_only_data", 32'(out4), 32'h0077);
        out_ready = 4'b1000;
        tick();
        check("mr_only_drain", 32'(out_valid), 32'h0);

        // 6: random soak against per-output queues
        stalled = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!stalled) begin
                in_valid = ($urandom_range(0, 3) != 0);
                select   = 2'($urandom_range(0, 3));
                in_data  = 16'($urandom);
            end
            out_ready = 4'($urandom_range(0, 15));
            #1;
            for (int i = 0; i < 4; i++) exp_valid[i] = (sb[i].size() != 0);
            check("soak_valid", 32'(out_valid), 32'(exp_valid));
            check("soak_ready", 32'(in_ready), 32'(sb[select].size() < 2));
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i] && sb[i].size() != 0) begin
                    check("soak_data", 32'(outs[i]), 32'(sb[i][0]));
                    void'(sb[i].pop_front());
                end
            end
            if (in_valid && in_ready) sb[select].push_back(in_data);
            stalled = in_valid & ~in_ready;
            tick();
        end
        drive(1'b0, 2'd0, 16'h0);
        out_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && sb[k].size() != 0) begin
                    check("drain_data", 32'(outs[k]), 32'(sb[k][0]));
                    void'(sb[k].pop_front());
                end
            end
            tick();
        end
        check("drain_valid", 32'(out_valid), 32'h0);
        check("drain_sb", 32'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
